// File: rtl/console_textbuf.sv
// console_textbuf: character-cell text buffer with a terminal-style writer and a pixel-driven reader.
// Latency: the reader returns codepoint/attribute 2 clk_pixel cycles after cx/cy; cx_out/cy_out are delayed to match.
// Backpressure: in_ready is high only in IDLE. It is low while a scrolled line is cleared (COLUMNS cycles) and
//   while the whole screen is cleared (COLUMNS*ROWS cycles, after reset or form feed).
//
// Ports:
//   clk_pixel, reset            - the only clock; asynchronous active-high reset
//   in_valid/in_ready/in_char/in_attr - character stream into the writer
//   cx, cy -> cx_out, cy_out    - pixel coordinates and their 2-cycle-delayed copies
//   codepoint, attribute        - cell contents at (cx_out, cy_out)
//   cursor_col, cursor_row      - writer cursor (row is logical: 0 = top of the visible screen)
module console_textbuf #(
  parameter int         BIT_WIDTH   = 12,
  parameter int         BIT_HEIGHT  = 11,
  parameter int         FONT_WIDTH  = 8,
  parameter int         FONT_HEIGHT = 16,
  parameter int         COLUMNS     = 80,
  parameter int         ROWS        = 30,
  parameter logic [7:0] BLANK_ATTR  = 8'h07
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_char,
  input  logic [7:0]                 in_attr,
  input  logic [BIT_WIDTH-1:0]       cx,
  input  logic [BIT_HEIGHT-1:0]      cy,
  output logic [BIT_WIDTH-1:0]       cx_out,
  output logic [BIT_HEIGHT-1:0]      cy_out,
  output logic [7:0]                 codepoint,
  output logic [7:0]                 attribute,
  output logic [$clog2(COLUMNS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0]    cursor_row
);

  localparam int COL_W  = $clog2(COLUMNS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CELLS  = COLUMNS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int FW_SH  = $clog2(FONT_WIDTH);
  localparam int FH_SH  = $clog2(FONT_HEIGHT);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1,
    CLEAR_ALL  = 2'd2
  } state_t;

  // Logical row -> physical row through the circular top-row pointer.
  // Both operands are below ROWS, so one conditional subtract is enough.
  function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
    return s[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLUMNS) + ADDR_W'(c);
  endfunction

  // ---------------------------------------------------------------------------
  // Cell RAM: {char, attr}; one write port, one registered read port
  // ---------------------------------------------------------------------------
  logic [15:0]       mem [CELLS];
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  always_ff @(posedge clk_pixel) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Writer FSM state
  // ---------------------------------------------------------------------------
  state_t            state, state_nx;
  logic [COL_W-1:0]  col_nx;
  logic [ROW_W-1:0]  row_nx;
  logic [ROW_W-1:0]  top_row, top_nx;
  logic [ROW_W-1:0]  clr_row, clr_row_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic              newline;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state      <= CLEAR_ALL;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      clr_row    <= '0;
      clr_cnt    <= '0;
    end else begin
      state      <= state_nx;
      cursor_col <= col_nx;
      cursor_row <= row_nx;
      top_row    <= top_nx;
      clr_row    <= clr_row_nx;
      clr_cnt    <= clr_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    col_nx     = cursor_col;
    row_nx     = cursor_row;
    top_nx     = top_row;
    clr_row_nx = clr_row;
    clr_cnt_nx = clr_cnt;
    in_ready   = 1'b0;
    we         = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    newline    = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_char)
            CH_CR: col_nx = '0;
            CH_LF: begin
              col_nx  = '0;
              newline = 1'b1;
            end
            CH_BS: begin
              if (cursor_col != '0) col_nx = cursor_col - 1'b1;
            end
            CH_FF: begin
              state_nx   = CLEAR_ALL;
              clr_cnt_nx = '0;
            end
            default: begin
              we      = 1'b1;
              wr_addr = cell_addr(wrap_row(cursor_row, top_row), cursor_col);
              wr_data = {in_char, in_attr};
              if (cursor_col == COL_W'(COLUMNS-1)) begin
                col_nx  = '0;
                newline = 1'b1;
              end else begin
                col_nx = cursor_col + 1'b1;
              end
            end
          endcase

          // At the bottom the cursor stays put and the screen scrolls: the old
          // top physical row becomes the new bottom row and must be blanked.
          if (newline) begin
            if (cursor_row != ROW_W'(ROWS-1)) begin
              row_nx = cursor_row + 1'b1;
            end else begin
              top_nx     = wrap_row(top_row, ROW_W'(1));
              clr_row_nx = top_row;
              clr_cnt_nx = '0;
              state_nx   = CLEAR_LINE;
            end
          end
        end
      end

      CLEAR_LINE: begin
        we      = 1'b1;
        wr_addr = cell_addr(clr_row, clr_cnt[COL_W-1:0]);
        wr_data = {8'h20, BLANK_ATTR};
        if (clr_cnt == ADDR_W'(COLUMNS-1)) state_nx = IDLE;
        else                               clr_cnt_nx = clr_cnt + 1'b1;
      end

      CLEAR_ALL: begin
        we      = 1'b1;
        wr_addr = clr_cnt;
        wr_data = {8'h20, BLANK_ATTR};
        if (clr_cnt == ADDR_W'(CELLS-1)) begin
          state_nx = IDLE;
          col_nx   = '0;
          row_nx   = '0;
          top_nx   = '0;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end

      default: begin
        state_nx   = CLEAR_ALL;
        clr_cnt_nx = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reader pipeline
  // ---------------------------------------------------------------------------
  logic [BIT_WIDTH-1:0]  pix_col;
  logic [BIT_HEIGHT-1:0] pix_row;
  logic                  rd_in_range;
  logic [COL_W-1:0]      rd_col;
  logic [ROW_W-1:0]      rd_lrow;
  logic [ADDR_W-1:0]     rd_addr;

  always_comb begin
    pix_col     = cx >> FW_SH;
    pix_row     = cy >> FH_SH;
    rd_in_range = (pix_col < BIT_WIDTH'(COLUMNS)) && (pix_row < BIT_HEIGHT'(ROWS));
    // Out-of-range coordinates are forced to cell 0 so the address stays inside the RAM.
    rd_col      = rd_in_range ? pix_col[COL_W-1:0] : '0;
    rd_lrow     = rd_in_range ? pix_row[ROW_W-1:0] : '0;
    rd_addr     = cell_addr(wrap_row(rd_lrow, top_row), rd_col);
  end

  logic [ADDR_W-1:0]     s1_addr;
  logic                  s1_in_range;
  logic [BIT_WIDTH-1:0]  s1_cx;
  logic [BIT_HEIGHT-1:0] s1_cy;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      s1_addr     <= '0;
      s1_in_range <= 1'b0;
      s1_cx       <= '0;
      s1_cy       <= '0;
    end else begin
      s1_addr     <= rd_addr;
      s1_in_range <= rd_in_range;
      s1_cx       <= cx;
      s1_cy       <= cy;
    end
  end

  // Non-blocking read alongside the write port: a same-address write in this
  // cycle is not yet visible, so the old cell contents are returned.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      codepoint <= 8'h20;
      attribute <= 8'h00;
      cx_out    <= '0;
      cy_out    <= '0;
    end else begin
      if (s1_in_range) begin
        codepoint <= mem[s1_addr][15:8];
        attribute <= mem[s1_addr][7:0];
      end else begin
        codepoint <= 8'h20;
        attribute <= 8'h00;
      end
      cx_out <= s1_cx;
      cy_out <= s1_cy;
    end
  end

endmodule

// File: tb/tb_console_textbuf.sv
module tb_console_textbuf;

  localparam int BW = 12;
  localparam int BH = 11;

  logic          clk_pixel = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [7:0]    in_char   = 8'h00;
  logic [7:0]    in_attr   = 8'h00;
  logic [BW-1:0] cx        = '0;
  logic [BH-1:0] cy        = '0;
  logic [BW-1:0] cx_out;
  logic [BH-1:0] cy_out;
  logic [7:0]    codepoint;
  logic [7:0]    attribute;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;

  int checks   = 0;
  int failures = 0;

  always #5 clk_pixel = ~clk_pixel;

  console_textbuf dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .cx         (cx),
    .cy         (cy),
    .cx_out     (cx_out),
    .cy_out     (cy_out),
    .codepoint  (codepoint),
    .attribute  (attribute),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Counts cycles until in_ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    wait_ready(n);
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic [7:0] ec, input logic [7:0] ea);
    cx = BW'(x);
    cy = BH'(y);
    tick();
    tick();
    chk({tag, "_cp"}, {24'd0, codepoint}, {24'd0, ec});
    chk({tag, "_attr"}, {24'd0, attribute}, {24'd0, ea});
    chk({tag, "_cxo"}, {20'd0, cx_out}, x);
    chk({tag, "_cyo"}, {21'd0, cy_out}, y);
  endtask

  task automatic chk_cursor(input string tag, input int col, input int row);
    chk({tag, "_col"}, {25'd0, cursor_col}, col);
    chk({tag, "_row"}, {27'd0, cursor_row}, row);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_cp", {24'd0, codepoint}, 32'h20);
    chk("rst_attr", {24'd0, attribute}, 32'h00);
    chk("rst_cxo", {20'd0, cx_out}, 32'd0);
    chk_cursor("rst", 0, 0);

    // Initial screen clear
    reset = 1'b0;
    chk("clr_ready0", {31'd0, in_ready}, 32'd0);
    wait_ready(n);
    chk("clr_all_cycles", n, 2400);
    probe("blank00", 0, 0, 8'h20, 8'h07);
    probe("blank_last", 632, 464, 8'h20, 8'h07);

    // Single character and its 8x16 cell
    send(8'h41, 8'h1E);
    chk_cursor("after_A", 1, 0);
    probe("A_0_0", 0, 0, 8'h41, 8'h1E);
    probe("A_7_15", 7, 15, 8'h41, 8'h1E);
    probe("A_3_9", 3, 9, 8'h41, 8'h1E);
    probe("next_cell", 8, 0, 8'h20, 8'h07);

    send(8'h0D, 8'h00);
    chk_cursor("after_CR", 0, 0);

    // 81 characters: wrap to row 1
    for (int i = 0; i < 81; i++) send(8'(8'h30 + (i % 40)), 8'(i));
    chk_cursor("wrap", 1, 1);
    probe("w_c0", 0, 0, 8'h30, 8'h00);
    probe("w_c5", 40, 0, 8'h35, 8'h05);
    probe("w_c79", 632, 0, 8'h57, 8'h4F);
    probe("w_81st", 0, 16, 8'h30, 8'h50);

    // Down to the bottom row, then scroll
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00);
    chk_cursor("bottom", 0, 29);
    send(8'h5A, 8'h2A);
    send(8'h0A, 8'h00);
    chk("scroll_ready0", {31'd0, in_ready}, 32'd0);
    wait_ready(n);
    chk("clr_line_cycles", n, 80);
    chk_cursor("scrolled", 0, 29);
    probe("sc_row0", 0, 0, 8'h30, 8'h50);
    probe("sc_row28", 0, 448, 8'h5A, 8'h2A);
    probe("sc_row29_c0", 0, 464, 8'h20, 8'h07);
    probe("sc_row29_c5", 40, 464, 8'h20, 8'h07);

    // Out-of-range probes and the last in-range pixel
    probe("oor_x", 640, 0, 8'h20, 8'h00);
    probe("oor_y", 0, 480, 8'h20, 8'h00);
    probe("edge_px", 639, 479, 8'h20, 8'h07);

    // Backspace
    send(8'h08, 8'h00);
    chk_cursor("bs_col0", 0, 29);
    send(8'h51, 8'h11);
    chk_cursor("after_Q", 1, 29);
    send(8'h08, 8'h00);
    chk_cursor("bs_col1", 0, 29);
    probe("bs_keep", 0, 464, 8'h51, 8'h11);
    send(8'h61, 8'h07);
    send(8'h62, 8'h07);
    send(8'h0D, 8'h00);
    chk_cursor("cr2", 0, 29);

    // Form feed
    send(8'h0C, 8'h00);
    chk("ff_ready0", {31'd0, in_ready}, 32'd0);
    wait_ready(n);
    chk("ff_cycles", n, 2400);
    chk_cursor("ff", 0, 0);
    probe("ff_00", 0, 0, 8'h20, 8'h07);
    probe("ff_row28", 0, 448, 8'h20, 8'h07);

    // Reset during CLEAR_LINE
    for (int i = 0; i < 29; i++) send(8'h0A, 8'h00);
    chk_cursor("bottom2", 0, 29);
    send(8'h0A, 8'h00);
    repeat (10) tick();
    chk("mid_clr_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #2;
    chk("mid_rst_cp", {24'd0, codepoint}, 32'h20);
    chk("mid_rst_attr", {24'd0, attribute}, 32'h00);
    chk_cursor("mid_rst", 0, 0);
    tick();
    tick();
    reset = 1'b0;
    wait_ready(n);
    chk("rst_clr_cycles", n, 2400);
    chk_cursor("post_rst", 0, 0);
    send(8'h4D, 8'h4D);
    probe("post_M", 0, 0, 8'h4D, 8'h4D);
    probe("post_row29", 0, 464, 8'h20, 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
